// File: rtl/shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe
//
// Purpose
//   Rijndael ShiftRows / InvShiftRows byte permutation for block widths of
//   4, 6 or 8 columns, wrapped in a valid/ready register pipeline of
//   PIPE_STAGES stages. The permutation is applied on the input side of the
//   first stage. The remaining stages only delay the beat. The direction is
//   chosen per beat through in_inv. A sideband tag travels with each beat.
//
// Parameters
//   NB           columns per state (4, 6 or 8); state width W = 32*NB
//   PIPE_STAGES  register stages (1..4) = latency in cycles when not stalled
//   TAG_W        sideband tag width
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   unit accepts the input beat this cycle (combinational)
//   in_inv     0 = ShiftRows, 1 = InvShiftRows, sampled with the beat
//   in_tag     sideband tag of the input beat
//   in_data    state, column-major; byte k = 4*c + r at in_data[W-1-8k -: 8]
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
//   out_tag    tag of the output beat
//   out_data   permuted state
// -----------------------------------------------------------------------------
module shift_rows_pipe #(
   parameter int NB          = 4,
   parameter int PIPE_STAGES = 1,
   parameter int TAG_W       = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_inv,
   input  logic [TAG_W-1:0]   in_tag,
   input  logic [32*NB-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [TAG_W-1:0]   out_tag,
   output logic [32*NB-1:0]   out_data
);

   localparam int W = 32 * NB;

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------
   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8 (got %0d)", NB);
   end

   if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
      $error("shift_rows_pipe: PIPE_STAGES must be 1..4 (got %0d)", PIPE_STAGES);
   end

   // Row rotation amount. The 256-bit block uses a wider spread on rows 2 and
   // 3 so that every column still mixes bytes from four distinct columns.
   function automatic int row_shift(input int r);
      if (NB == 8) begin
         if (r == 2) return 3;
         if (r == 3) return 4;
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Permutation network
   // Both directions are pure wiring. Only the final 2:1 select per byte costs
   // logic, so computing both and picking one is cheaper than muxing indices.
   // ---------------------------------------------------------------------------
   logic [W-1:0] fwd_data;
   logic [W-1:0] inv_data;
   logic [W-1:0] perm_data;

   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int SRC_F = (c + row_shift(r)) % NB;
         localparam int SRC_I = (c - row_shift(r) + NB) % NB;
         localparam int DST   = W - 1 - 8 * (4 * c + r);
         assign fwd_data[DST -: 8] = in_data[W - 1 - 8 * (4 * SRC_F + r) -: 8];
         assign inv_data[DST -: 8] = in_data[W - 1 - 8 * (4 * SRC_I + r) -: 8];
      end
   end

   assign perm_data = in_inv ? inv_data : fwd_data;

   // ---------------------------------------------------------------------------
   // Pipeline stage registers. Index 0 is the stage nearest the input.
   // ---------------------------------------------------------------------------
   logic [PIPE_STAGES-1:0] v_q;
   logic [PIPE_STAGES-1:0] v_d;
   logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
   logic [TAG_W-1:0]       tag_d  [PIPE_STAGES];
   logic [W-1:0]           data_q [PIPE_STAGES];
   logic [W-1:0]           data_d [PIPE_STAGES];

   // rdy[s] high means stage s loads from its upstream on the next edge.
   logic [PIPE_STAGES-1:0] rdy;

   // Ready chain, evaluated from the output end backwards. An empty stage is
   // always ready, which lets bubbles collapse while the output is stalled.
   // A local running value keeps rdy a pure output of this block.
   always_comb begin
      logic ready_chain;
      ready_chain = out_ready;
      rdy         = '0;
      for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
         ready_chain = !v_q[s] || ready_chain;
         rdy[s]      = ready_chain;
      end
   end

   // Next-state logic for all stages.
   // NOTE: every _d signal is given its hold value before any conditional
   // update, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      v_d    = v_q;
      tag_d  = tag_q;
      data_d = data_q;

      // Stage 0 captures the freshly permuted input beat.
      if (rdy[0]) begin
         v_d[0] = in_valid;
         // Payload only moves with a valid beat; an empty stage keeps its old
         // contents, which avoids needless toggling of the wide data path.
         if (in_valid) begin
            tag_d[0]  = in_tag;
            data_d[0] = perm_data;
         end
      end

      // Later stages are plain delay elements.
      for (int s = 1; s < PIPE_STAGES; s++) begin
         if (rdy[s]) begin
            v_d[s] = v_q[s-1];
            if (v_q[s-1]) begin
               tag_d[s]  = tag_q[s-1];
               data_d[s] = data_q[s-1];
            end
         end
      end
   end

   // NOTE: the payload registers are reset along with the valid bits so that a
   // freshly reset unit drives all-zero out_data/out_tag instead of stale data.
   // NOTE: state registers are written with non-blocking assignments so every
   // stage samples its upstream's pre-edge value and beats advance one stage
   // per clock regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int s = 0; s < PIPE_STAGES; s++) begin
            tag_q[s]  <= '0;
            data_q[s] <= '0;
         end
      end else begin
         v_q    <= v_d;
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Port mapping
   // ---------------------------------------------------------------------------
   assign in_ready  = rdy[0];
   assign out_valid = v_q[PIPE_STAGES-1];
   assign out_tag   = tag_q[PIPE_STAGES-1];
   assign out_data  = data_q[PIPE_STAGES-1];

   // ---------------------------------------------------------------------------
   // Handshake properties
   // ---------------------------------------------------------------------------
   // A stalled output beat must not change underneath the consumer.
   a_out_stable : assert property (
      @(posedge clk) disable iff (!rst_n)
         (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_tag))
   );

   // The producer may not withdraw a beat before it has been taken.
   a_in_hold : assert property (
      @(posedge clk) disable iff (!rst_n)
         (in_valid && !in_ready) |=> in_valid
   );

endmodule

// File: tb/tb_shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_rows_pipe
//
// Three instances of shift_rows_pipe share clock and reset:
//   u_a : NB=4, PIPE_STAGES=1  table of hand-computed AES-128 vectors
//   u_b : NB=8, PIPE_STAGES=1  256-bit block, row offsets {0,1,3,4}
//   u_c : NB=4, PIPE_STAGES=3  streaming, backpressure and mid-stream reset
// -----------------------------------------------------------------------------
module tb_shift_rows_pipe;

   localparam int TAG_W = 4;
   localparam int PS_C  = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- u_a ----------------
   logic             a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
   logic [TAG_W-1:0] a_in_tag, a_out_tag;
   logic [127:0]     a_in_data, a_out_data;

   // ---------------- u_b ----------------
   logic             b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
   logic [TAG_W-1:0] b_in_tag, b_out_tag;
   logic [255:0]     b_in_data, b_out_data;

   // ---------------- u_c ----------------
   logic             c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready;
   logic [TAG_W-1:0] c_in_tag, c_out_tag;
   logic [127:0]     c_in_data, c_out_data;

   shift_rows_pipe #(.NB(4), .PIPE_STAGES(1), .TAG_W(TAG_W)) u_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
      .in_tag(a_in_tag), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_tag(a_out_tag), .out_data(a_out_data)
   );

   shift_rows_pipe #(.NB(8), .PIPE_STAGES(1), .TAG_W(TAG_W)) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
      .in_tag(b_in_tag), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_tag(b_out_tag), .out_data(b_out_data)
   );

   shift_rows_pipe #(.NB(4), .PIPE_STAGES(PS_C), .TAG_W(TAG_W)) u_c (
      .clk(clk), .rst_n(rst_n),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv),
      .in_tag(c_in_tag), .in_data(c_in_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_tag(c_out_tag), .out_data(c_out_data)
   );

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference permutation written directly from the row/column definition.
   // The state occupies the low 32*nb bits of the 256-bit container.
   function automatic logic [255:0] model(input int nb, input logic inv, input logic [255:0] d);
      logic [255:0] res;
      int           sh [4];
      int           w;
      int           src;
      res   = '0;
      w     = 32 * nb;
      sh[0] = 0;
      sh[1] = 1;
      sh[2] = (nb == 8) ? 3 : 2;
      sh[3] = (nb == 8) ? 4 : 3;
      for (int c = 0; c < nb; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
            res[w - 1 - 8 * (4 * c + r) -: 8] = d[w - 1 - 8 * (4 * src + r) -: 8];
         end
      end
      return res;
   endfunction

   function automatic logic [127:0] pat(input int i);
      return {32'h01234567 + 32'(i), 32'h89abcdef ^ 32'(i << 4),
              32'hc3000000 | 32'(i), 32'h5a5aa5a5};
   endfunction

   typedef struct {
      logic         inv;
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [127:0]     data;
   } beat_t;

   beat_t exp_q [$];

   // Drives a stream of n_beats into u_c (alternating direction, tag = index)
   // for n_cycles, holding out_ready low for the first `stall` cycles.
   // Inputs change 1 time unit after a rising edge; handshakes and outputs are
   // evaluated on the falling edge.
   task automatic run_c(input int first_idx, input int n_beats, input int n_cycles,
                        input int stall, output int first_out, output int last_out,
                        output int got);
      int               sent;
      logic             holding;
      logic [127:0]     held_data;
      logic [TAG_W-1:0] held_tag;
      beat_t            e;
      sent      = 0;
      holding   = 1'b0;
      held_data = '0;
      held_tag  = '0;
      first_out = -1;
      last_out  = -1;
      got       = 0;
      for (int cyc = 0; cyc < n_cycles; cyc++) begin
         c_out_ready = (cyc >= stall);
         if (sent < n_beats) begin
            c_in_valid = 1'b1;
            c_in_inv   = ((first_idx + sent) % 2 == 1);
            c_in_tag   = TAG_W'(first_idx + sent);
            c_in_data  = pat(first_idx + sent);
         end else begin
            c_in_valid = 1'b0;
         end
         @(negedge clk);
         if (stall > 0 && cyc == stall - 1) begin
            check("c_beats_accepted_while_stalled", 256'(sent), 256'(PS_C));
            check("c_in_ready_when_full", 256'(c_in_ready), 256'(0));
         end
         if (c_in_valid && c_in_ready) begin
            e.tag  = c_in_tag;
            e.data = 128'(model(4, c_in_inv, 256'(c_in_data)));
            exp_q.push_back(e);
            sent++;
         end
         if (c_out_valid) begin
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (holding) begin
               check($sformatf("c_stall_data_stable cyc%0d", cyc), 256'(c_out_data), 256'(held_data));
               check($sformatf("c_stall_tag_stable cyc%0d", cyc), 256'(c_out_tag), 256'(held_tag));
            end
            if (c_out_ready) begin
               holding = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL c_unexpected_beat cyc%0d: got tag %0h data %0h expected no beat",
                           cyc, c_out_tag, c_out_data);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("c_out_tag cyc%0d", cyc), 256'(c_out_tag), 256'(e.tag));
                  check($sformatf("c_out_data cyc%0d", cyc), 256'(c_out_data), 256'(e.data));
                  got++;
               end
            end else begin
               holding   = 1'b1;
               held_data = c_out_data;
               held_tag  = c_out_tag;
            end
         end
         @(posedge clk);
         #1;
      end
      c_in_valid = 1'b0;
   endtask

   // Safety net: the sequence below is bounded, this only catches a stuck run.
   initial begin
      #200000;
      $display("FAIL watchdog: got no summary by time limit expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      vec_t         vecs [7];
      logic [255:0] b_orig;
      logic [255:0] b_fwd;
      int           f, l, g;

      // Hand-computed AES-128 vectors, byte 0 in the MSBs.
      vecs[0] = '{1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
      vecs[1] = '{1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd42711aee0bf98f1b8b45de51e415230};
      vecs[2] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h000d0a0704010e0b0805020f0c090603};
      vecs[3] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b};
      vecs[4] = '{1'b1, 128'h00050a0f04090e03080d02070c01060b, 128'h000102030405060708090a0b0c0d0e0f};
      // Single populated column: shows each row's wrap-around destination.
      vecs[5] = '{1'b0, 128'hffffffff000000000000000000000000, 128'hff000000000000ff0000ff0000ff0000};
      vecs[6] = '{1'b1, 128'hffffffff000000000000000000000000, 128'hff00000000ff00000000ff00000000ff};

      a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_tag = '0; a_in_data = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_tag = '0; b_in_data = '0; b_out_ready = 1'b1;
      c_in_valid = 1'b0; c_in_inv = 1'b0; c_in_tag = '0; c_in_data = '0; c_out_ready = 1'b1;

      // ---- asynchronous reset, checked before any clock edge ----
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("a_reset_out_valid", 256'(a_out_valid), 256'(0));
      check("a_reset_out_data",  256'(a_out_data),  256'(0));
      check("a_reset_out_tag",   256'(a_out_tag),   256'(0));
      check("a_reset_in_ready",  256'(a_in_ready),  256'(1));
      check("b_reset_out_valid", 256'(b_out_valid), 256'(0));
      check("b_reset_out_data",  b_out_data,        256'(0));
      check("c_reset_out_valid", 256'(c_out_valid), 256'(0));
      check("c_reset_out_data",  256'(c_out_data),  256'(0));
      check("c_reset_in_ready",  256'(c_in_ready),  256'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---- NB=4 table, back-to-back beats, latency 1 ----
      for (int i = 0; i < 7; i++) begin
         a_in_valid = 1'b1;
         a_in_inv   = vecs[i].inv;
         a_in_tag   = TAG_W'(i);
         a_in_data  = vecs[i].din;
         @(negedge clk);
         check($sformatf("a_in_ready[%0d]", i), 256'(a_in_ready), 256'(1));
         @(posedge clk);
         #1;
         a_in_valid = 1'b0;
         check($sformatf("a_out_valid[%0d]", i), 256'(a_out_valid), 256'(1));
         check($sformatf("a_out_data[%0d]", i),  256'(a_out_data),  256'(vecs[i].dout));
         check($sformatf("a_out_tag[%0d]", i),   256'(a_out_tag),   256'(i));
      end
      @(posedge clk);
      #1;
      check("a_idle_after_stream", 256'(a_out_valid), 256'(0));

      // ---- NB=8: bytes 0x00..0x1f ----
      for (int k = 0; k < 32; k++) b_orig[255 - 8 * k -: 8] = 8'(k);
      b_fwd = model(8, 1'b0, b_orig);

      b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_tag = 4'h1; b_in_data = b_orig;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      check("b_fwd_valid",  256'(b_out_valid), 256'(1));
      check("b_fwd_col0",   256'(b_out_data[255:224]), 256'(32'h00050e13));
      check("b_fwd_col1",   256'(b_out_data[223:192]), 256'(32'h04091217));
      check("b_fwd_full",   b_out_data, b_fwd);
      check("b_fwd_tag",    256'(b_out_tag), 256'(4'h1));

      b_in_valid = 1'b1; b_in_inv = 1'b1; b_in_tag = 4'h2; b_in_data = b_fwd;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      check("b_inv_roundtrip", b_out_data, b_orig);

      b_in_valid = 1'b1; b_in_inv = 1'b1; b_in_tag = 4'h3; b_in_data = b_orig;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      check("b_inv_col0", 256'(b_out_data[255:224]), 256'(32'h001d1613));
      check("b_inv_full", b_out_data, model(8, 1'b1, b_orig));

      // ---- PIPE_STAGES=3: 6 back-to-back beats, alternating direction ----
      run_c(0, 6, 12, 0, f, l, g);
      check("c_stream_first_out_cycle", 256'(f), 256'(PS_C));
      check("c_stream_last_out_cycle",  256'(l), 256'(PS_C + 5));
      check("c_stream_beats_out",       256'(g), 256'(6));
      check("c_stream_scoreboard_empty", 256'(exp_q.size()), 256'(0));

      // ---- backpressure: out_ready low for 5 cycles, then drain ----
      run_c(0, 8, 22, 5, f, l, g);
      check("c_bp_first_out_cycle",     256'(f), 256'(PS_C));
      check("c_bp_beats_out",           256'(g), 256'(8));
      check("c_bp_scoreboard_empty",    256'(exp_q.size()), 256'(0));
      check("c_bp_in_ready_after",      256'(c_in_ready), 256'(1));

      // ---- reset with two beats in flight ----
      c_out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         c_in_valid = 1'b1;
         c_in_inv   = 1'b0;
         c_in_tag   = TAG_W'(10 + i);
         c_in_data  = pat(10 + i);
         @(posedge clk);
         #1;
      end
      c_in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("c_pre_reset_out_valid", 256'(c_out_valid), 256'(1));
      check("c_pre_reset_out_data",  256'(c_out_data), model(4, 1'b0, 256'(pat(10))));
      #2 rst_n = 1'b0;
      #1;
      check("c_midreset_out_valid", 256'(c_out_valid), 256'(0));
      check("c_midreset_out_data",  256'(c_out_data),  256'(0));
      check("c_midreset_out_tag",   256'(c_out_tag),   256'(0));
      check("c_midreset_in_ready",  256'(c_in_ready),  256'(1));
      @(negedge clk);
      @(negedge clk);
      rst_n       = 1'b1;
      c_out_ready = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("c_no_stale_beat[%0d]", i), 256'(c_out_valid), 256'(0));
      end
      @(posedge clk);
      #1;
      run_c(12, 1, 6, 0, f, l, g);
      check("c_post_reset_first_out", 256'(f), 256'(PS_C));
      check("c_post_reset_beats_out", 256'(g), 256'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
